// File: rtl/dac_wave_gen.sv
// Waveform sample source for the MCP4725 writer: a 16-bit phase accumulator feeds a
// sawtooth/triangle/square/sine shaper, one sample every TICK_DIV clocks.
module dac_wave_gen #(
  parameter int TICK_DIV = 7250,
  parameter int PHASE_W  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [1:0]  mode,
  input  logic [15:0] step,
  input  logic        phase_clr,
  output logic [7:0]  DATAo,
  output logic        sample_valid
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  localparam logic [1:0] MODE_SAW = 2'b00;
  localparam logic [1:0] MODE_TRI = 2'b01;
  localparam logic [1:0] MODE_SQR = 2'b10;

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [1:0]         mode_l_q, mode_l_d;
  logic               tick_dly_q, tick_dly_d;
  logic [7:0]         data_q, data_d;
  logic               vld_q, vld_d;
  logic               tick;

  // Quarter-wave table: 128 + floor(127*sin(2*pi*i/256)), i = 0..63.
  function automatic logic [7:0] sine_lut(input logic [5:0] i);
    logic [7:0] v;
    v = 8'd128;
    case (i)
      6'd0:  v = 8'd128;
      6'd1:  v = 8'd131;
      6'd2:  v = 8'd134;
      6'd3:  v = 8'd137;
      6'd4:  v = 8'd140;
      6'd5:  v = 8'd143;
      6'd6:  v = 8'd146;
      6'd7:  v = 8'd149;
      6'd8:  v = 8'd152;
      6'd9:  v = 8'd155;
      6'd10: v = 8'd158;
      6'd11: v = 8'd161;
      6'd12: v = 8'd164;
      6'd13: v = 8'd167;
      6'd14: v = 8'd170;
      6'd15: v = 8'd173;
      6'd16: v = 8'd176;
      6'd17: v = 8'd179;
      6'd18: v = 8'd182;
      6'd19: v = 8'd185;
      6'd20: v = 8'd187;
      6'd21: v = 8'd190;
      6'd22: v = 8'd193;
      6'd23: v = 8'd195;
      6'd24: v = 8'd198;
      6'd25: v = 8'd201;
      6'd26: v = 8'd203;
      6'd27: v = 8'd206;
      6'd28: v = 8'd208;
      6'd29: v = 8'd210;
      6'd30: v = 8'd213;
      6'd31: v = 8'd215;
      6'd32: v = 8'd217;
      6'd33: v = 8'd219;
      6'd34: v = 8'd222;
      6'd35: v = 8'd224;
      6'd36: v = 8'd226;
      6'd37: v = 8'd228;
      6'd38: v = 8'd230;
      6'd39: v = 8'd231;
      6'd40: v = 8'd233;
      6'd41: v = 8'd235;
      6'd42: v = 8'd236;
      6'd43: v = 8'd238;
      6'd44: v = 8'd240;
      6'd45: v = 8'd241;
      6'd46: v = 8'd242;
      6'd47: v = 8'd244;
      6'd48: v = 8'd245;
      6'd49: v = 8'd246;
      6'd50: v = 8'd247;
      6'd51: v = 8'd248;
      6'd52: v = 8'd249;
      6'd53: v = 8'd250;
      6'd54: v = 8'd251;
      6'd55: v = 8'd251;
      6'd56: v = 8'd252;
      6'd57: v = 8'd253;
      6'd58: v = 8'd253;
      6'd59: v = 8'd254;
      6'd60: v = 8'd254;
      6'd61: v = 8'd254;
      6'd62: v = 8'd254;
      6'd63: v = 8'd254;
      default: v = 8'd128;
    endcase
    return v;
  endfunction

  function automatic logic [7:0] wave(input logic [15:0] ph, input logic [1:0] m);
    logic [7:0] p;
    logic [7:0] tri_v;
    logic [5:0] idx;
    logic [7:0] s;
    p     = ph[15:8];
    tri_v = {p[6:0], 1'b0};
    // 63-idx is the bitwise inverse of a 6-bit index, 255-x the inverse of a byte.
    idx   = ph[14] ? ~ph[13:8] : ph[13:8];
    s     = sine_lut(idx);
    case (m)
      MODE_SAW: return p;
      MODE_TRI: return p[7] ? ~tri_v : tri_v;
      MODE_SQR: return p[7] ? 8'h00 : 8'hFF;
      default:  return ph[15] ? ~s : s;
    endcase
  endfunction

  always_comb begin
    tick  = en && (cnt_q == CNT_MAX);
    cnt_d = cnt_q + CNT_W'(1);
    if (phase_clr || !en || tick) begin
      cnt_d = '0;
    end

    phase_d    = phase_q;
    mode_l_d   = mode_l_q;
    tick_dly_d = 1'b0;
    // A clear wins over a coincident tick, so that tick's sample never reaches stage 2.
    if (phase_clr) begin
      phase_d = '0;
    end else if (tick) begin
      phase_d    = phase_q + step;
      mode_l_d   = mode;
      tick_dly_d = 1'b1;
    end

    data_d = data_q;
    vld_d  = 1'b0;
    if (tick_dly_q) begin
      data_d = wave(phase_q, mode_l_q);
      vld_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      phase_q    <= '0;
      mode_l_q   <= 2'b00;
      tick_dly_q <= 1'b0;
      data_q     <= 8'h80;
      vld_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      mode_l_q   <= mode_l_d;
      tick_dly_q <= tick_dly_d;
      data_q     <= data_d;
      vld_q      <= vld_d;
    end
  end

  assign DATAo        = data_q;
  assign sample_valid = vld_q;

endmodule
